panda_pc_ctrl: RTL and testbench

Parametrised program-counter controller for the Panda Core fetch stage, successor to the single-redirect PC register. Holds the fetch PC and selects the next PC from `NumRedirect` prioritised redirect channels (branch, jump, trap, …) or the sequential increment. Redirects arriving while fetch is stalled are captured in a pending register and applied when the stall lifts. Misaligned redirect targets are reported.

---
 rtl/panda_pkg.sv | 22 ++
 rtl/panda_pc_ctrl_if.sv | 43 ++++
 rtl/panda_pc_arbiter.sv | 32 +++
 rtl/panda_pc_ctrl.sv | 98 +++++++++
 tb/tb_panda_pc_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/panda_pkg.sv
//------------------------------------------------------------------------------
// Module  : panda_pkg
// Brief   : Shared constants and helpers for the Panda Core PC controller.
//           Optional feature macro: PANDA_PC_COMPRESSED_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package panda_pkg;

    localparam int PcIncStd           = 4;
    localparam int PcIncComp          = 2;
    localparam int ResetVectorDefault = 0;

    // Low-address bits that must be zero in a legal fetch target.
    function automatic logic [1:0] align_low_mask(input logic comp_en);
        return comp_en ? 2'b01 : 2'b11;
    endfunction

endpackage

`default_nettype wire

// File: rtl/panda_pc_ctrl_if.sv
//------------------------------------------------------------------------------
// Module  : panda_pc_ctrl_if
// Brief   : Stall/redirect request bundle and PC outputs of the fetch PC
//           controller. Macro PANDA_PC_COMPRESSED_EN adds compressed_i.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface panda_pc_ctrl_if #(
    parameter int Width       = 32,
    parameter int NumRedirect = 2
);

    logic                                stall_i;
    logic [NumRedirect-1:0]              redirect_valid_i;
    logic [NumRedirect-1:0][Width-1:0]   redirect_target_i;
`ifdef PANDA_PC_COMPRESSED_EN
    logic                                compressed_i;
`endif
    logic [Width-1:0]                    pc_o;
    logic [Width-1:0]                    pc_inc_o;
    logic                                pending_o;
    logic                                misaligned_o;

    modport master (
        output stall_i, redirect_valid_i, redirect_target_i,
`ifdef PANDA_PC_COMPRESSED_EN
        output compressed_i,
`endif
        input  pc_o, pc_inc_o, pending_o, misaligned_o
    );

    modport slave (
        input  stall_i, redirect_valid_i, redirect_target_i,
`ifdef PANDA_PC_COMPRESSED_EN
        input  compressed_i,
`endif
        output pc_o, pc_inc_o, pending_o, misaligned_o
    );

endinterface

`default_nettype wire

// File: rtl/panda_pc_arbiter.sv
//------------------------------------------------------------------------------
// Module  : panda_pc_arbiter
// Brief   : Fixed-priority redirect select; channel 0 has highest priority.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module panda_pc_arbiter #(
    parameter int Width       = 32,
    parameter int NumRedirect = 2
) (
    input  wire logic [NumRedirect-1:0]            valid,
    input  wire logic [NumRedirect-1:0][Width-1:0] targets,
    output logic                                   any_valid,
    output logic [Width-1:0]                       sel_target
);

    // Scanning from the top down lets the lowest asserted index land last.
    always_comb begin
        sel_target = '0;
        for (int i = NumRedirect - 1; i >= 0; i--) begin
            if (valid[i]) begin
                sel_target = targets[i];
            end
        end
    end

    assign any_valid = |valid;

endmodule

`default_nettype wire

// File: rtl/panda_pc_ctrl.sv
//------------------------------------------------------------------------------
// Module  : panda_pc_ctrl
// Brief   : Fetch-stage PC register with prioritised redirects, stall-time
//           pending capture and misalignment reporting.
//           Macro PANDA_PC_COMPRESSED_EN enables 16-bit instruction support.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module panda_pc_ctrl
    import panda_pkg::*;
#(
    parameter int Width       = 32,
    parameter int NumRedirect = 2,
    parameter logic [Width-1:0] ResetVector = Width'(ResetVectorDefault)
) (
    input  wire logic        clk_i,
    input  wire logic        rst_ni,
    panda_pc_ctrl_if.slave   bus
);

`ifdef PANDA_PC_COMPRESSED_EN
    localparam logic c_comp_en = 1'b1;
`else
    localparam logic c_comp_en = 1'b0;
`endif
    localparam logic [1:0] c_low_mask = align_low_mask(c_comp_en);

    logic [Width-1:0] r_pc;
    logic [Width-1:0] r_pend_target;
    logic             r_pend_valid;
    logic             r_misaligned;

    logic             w_any_valid;
    logic [Width-1:0] w_sel_target;
    logic [Width-1:0] w_inc;
    logic [Width-1:0] w_pc_inc;
    logic             w_apply;
    logic [Width-1:0] w_raw_target;
    logic [Width-1:0] w_aligned_target;
    logic             w_target_misaligned;

    panda_pc_arbiter #(
        .Width       (Width),
        .NumRedirect (NumRedirect)
    ) u_arbiter (
        .valid      (bus.redirect_valid_i),
        .targets    (bus.redirect_target_i),
        .any_valid  (w_any_valid),
        .sel_target (w_sel_target)
    );

`ifdef PANDA_PC_COMPRESSED_EN
    assign w_inc = bus.compressed_i ? Width'(PcIncComp) : Width'(PcIncStd);
`else
    assign w_inc = Width'(PcIncStd);
`endif
    assign w_pc_inc = r_pc + w_inc;

    // A live redirect always beats a pending one; pending is only consulted
    // when no channel is asserted in the release cycle.
    assign w_apply             = w_any_valid || r_pend_valid;
    assign w_raw_target        = w_any_valid ? w_sel_target : r_pend_target;
    assign w_aligned_target    = {w_raw_target[Width-1:2], w_raw_target[1:0] & ~c_low_mask};
    assign w_target_misaligned = |(w_raw_target[1:0] & c_low_mask);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_pc          <= ResetVector;
            r_pend_target <= '0;
            r_pend_valid  <= 1'b0;
            r_misaligned  <= 1'b0;
        end else if (bus.stall_i) begin
            r_misaligned <= 1'b0;
            if (w_any_valid) begin
                r_pend_target <= w_sel_target;
                r_pend_valid  <= 1'b1;
            end
        end else begin
            r_pend_valid <= 1'b0;
            if (w_apply) begin
                r_pc         <= w_aligned_target;
                r_misaligned <= w_target_misaligned;
            end else begin
                r_pc         <= w_pc_inc;
                r_misaligned <= 1'b0;
            end
        end
    end

    assign bus.pc_o         = r_pc;
    assign bus.pc_inc_o     = w_pc_inc;
    assign bus.pending_o    = r_pend_valid;
    assign bus.misaligned_o = r_misaligned;

endmodule

`default_nettype wire

// File: tb/tb_panda_pc_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_panda_pc_ctrl
// Brief   : Self-checking bench for panda_pc_ctrl: directed vector table plus
//           randomized traffic against a behavioural model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_panda_pc_ctrl;

`ifdef PANDA_PC_COMPRESSED_EN
    localparam int GRAN = 2;
`else
    localparam int GRAN = 4;
`endif
    localparam logic [31:0] AMASK = ~(32'(GRAN) - 32'd1);

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic [1:0]  valid;
        logic [31:0] t0;
        logic [31:0] t1;
        logic        comp;
        logic [31:0] pc;
        logic        pend;
        logic        mis;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   nvec = 0;
    int   nerr = 0;
    vec_t tbl[$];

    panda_pc_ctrl_if #(.Width(32), .NumRedirect(2)) bus ();

    panda_pc_ctrl #(
        .Width       (32),
        .NumRedirect (2),
        .ResetVector (32'h0)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic s, input logic [1:0] v,
                       input logic [31:0] t0, input logic [31:0] t1, input logic c,
                       input logic [31:0] pc, input logic pend, input logic mis);
        vec_t e;
        e.rst_n = r; e.stall = s; e.valid = v; e.t0 = t0; e.t1 = t1; e.comp = c;
        e.pc = pc; e.pend = pend; e.mis = mis;
        tbl.push_back(e);
    endtask

    // Drive one cycle of inputs, let the edge pass, then compare.
    task automatic step(input string name, input vec_t e);
        logic [31:0] exp_inc;
        rst_n                     = e.rst_n;
        bus.stall_i               = e.stall;
        bus.redirect_valid_i      = e.valid;
        bus.redirect_target_i[0]  = e.t0;
        bus.redirect_target_i[1]  = e.t1;
`ifdef PANDA_PC_COMPRESSED_EN
        bus.compressed_i          = e.comp;
        exp_inc = e.pc + (e.comp ? 32'd2 : 32'd4);
`else
        exp_inc = e.pc + 32'd4;
`endif
        @(posedge clk);
        #1;
        nvec++;
        if (bus.pc_o !== e.pc || bus.pending_o !== e.pend ||
            bus.misaligned_o !== e.mis || bus.pc_inc_o !== exp_inc) begin
            nerr++;
            $display("FAIL %s: got pc=%h inc=%h pend=%b mis=%b, want pc=%h inc=%h pend=%b mis=%b",
                     name, bus.pc_o, bus.pc_inc_o, bus.pending_o, bus.misaligned_o,
                     e.pc, exp_inc, e.pend, e.mis);
        end
    endtask

    // Behavioural reference state for the random phase.
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_ptgt;
    logic        m_mis;

    initial begin
        vec_t e;
        logic [31:0] tgt;
        logic        have;

        rst_n = 1'b0;
        bus.stall_i = 1'b0;
        bus.redirect_valid_i = '0;
        bus.redirect_target_i = '0;
`ifdef PANDA_PC_COMPRESSED_EN
        bus.compressed_i = 1'b0;
`endif

        //  rst stall valid t0             t1            comp  pc                       pend mis
        add(0, 0, 2'b00, 32'h0,          32'h0,         0, 32'h0,                     0, 0);
        add(0, 1, 2'b11, 32'h44,         32'h88,        0, 32'h0,                     0, 0);
        add(1, 0, 2'b00, 32'h0,          32'h0,         0, 32'h4,                     0, 0);
        add(1, 0, 2'b00, 32'h0,          32'h0,         0, 32'h8,                     0, 0);
        add(1, 0, 2'b11, 32'h100,        32'h200,       0, 32'h100,                   0, 0);
        add(1, 0, 2'b00, 32'h0,          32'h0,         0, 32'h104,                   0, 0);
        add(1, 0, 2'b01, 32'h10,         32'h0,         0, 32'h10,                    0, 0);
        add(1, 1, 2'b00, 32'h0,          32'h0,         0, 32'h10,                    0, 0);
        add(1, 1, 2'b10, 32'h0,          32'h40,        0, 32'h10,                    1, 0);
        add(1, 1, 2'b10, 32'h0,          32'h80,        0, 32'h10,                    1, 0);
        add(1, 1, 2'b00, 32'h0,          32'h0,         0, 32'h10,                    1, 0);
        add(1, 0, 2'b00, 32'h0,          32'h0,         0, 32'h80,                    0, 0);
        add(1, 0, 2'b00, 32'h0,          32'h0,         0, 32'h84,                    0, 0);
        add(1, 1, 2'b10, 32'h0,          32'h80,        0, 32'h84,                    1, 0);
        add(1, 0, 2'b01, 32'h300,        32'h0,         0, 32'h300,                   0, 0);
        add(1, 0, 2'b00, 32'h0,          32'h0,         0, 32'h304,                   0, 0);
        add(1, 0, 2'b01, 32'h103,        32'h0,         0, 32'h103 & AMASK,           0, 1);
        add(1, 0, 2'b00, 32'h0,          32'h0,         0, (32'h103 & AMASK) + 32'd4, 0, 0);
        add(1, 1, 2'b10, 32'h0,          32'h203,       0, (32'h103 & AMASK) + 32'd4, 1, 0);
        add(1, 0, 2'b00, 32'h0,          32'h0,         0, 32'h203 & AMASK,           0, 1);
        add(1, 0, 2'b01, 32'hFFFF_FFFC,  32'h0,         0, 32'hFFFF_FFFC,             0, 0);
        add(1, 0, 2'b00, 32'h0,          32'h0,         0, 32'h0,                     0, 0);
        add(1, 0, 2'b00, 32'h0,          32'h0,         0, 32'h4,                     0, 0);
        add(1, 1, 2'b01, 32'h558,        32'h0,         0, 32'h4,                     1, 0);
        add(0, 1, 2'b01, 32'h558,        32'h0,         0, 32'h0,                     0, 0);
        add(1, 0, 2'b00, 32'h0,          32'h0,         0, 32'h4,                     0, 0);
`ifdef PANDA_PC_COMPRESSED_EN
        add(1, 0, 2'b01, 32'h103,        32'h0,         1, 32'h102,                   0, 1);
        add(1, 0, 2'b00, 32'h0,          32'h0,         1, 32'h104,                   0, 0);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        m_pc = '0; m_pend = 1'b0; m_ptgt = '0; m_mis = 1'b0;
        for (int n = 0; n < 400; n++) begin
            e.rst_n = (n == 0) ? 1'b0 : ($urandom_range(31) != 0);
            e.stall = ($urandom_range(2) == 0);
            e.valid = ($urandom_range(1) == 0) ? 2'(  $urandom_range(3)) : 2'b00;
            e.t0    = $urandom;
            e.t1    = $urandom;
            if ($urandom_range(7) == 0) e.t0 = 32'hFFFF_FFF0 | (e.t0 & 32'hF);
`ifdef PANDA_PC_COMPRESSED_EN
            e.comp  = 1'($urandom_range(1));
`else
            e.comp  = 1'b0;
`endif
            have = 1'b0;
            tgt  = '0;
            for (int c = 0; c < 2; c++) begin
                if (!have && e.valid[c]) begin
                    have = 1'b1;
                    tgt  = (c == 0) ? e.t0 : e.t1;
                end
            end
            if (!e.rst_n) begin
                m_pc = 32'h0; m_pend = 1'b0; m_mis = 1'b0;
            end else if (e.stall) begin
                m_mis = 1'b0;
                if (have) begin
                    m_pend = 1'b1;
                    m_ptgt = tgt;
                end
            end else begin
                if (!have && m_pend) begin
                    have = 1'b1;
                    tgt  = m_ptgt;
                end
                if (have) begin
                    m_pc  = tgt - (tgt % GRAN);
                    m_mis = (tgt % GRAN) != 0;
                end else begin
                    m_pc  = m_pc + ((e.comp && GRAN == 2) ? 32'd2 : 32'd4);
                    m_mis = 1'b0;
                end
                m_pend = 1'b0;
            end
            e.pc = m_pc; e.pend = m_pend; e.mis = m_mis;
            step($sformatf("rand%0d", n), e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
